// File: rtl/nco_iq_phase_est_pkg.sv
// Shared constants and pipeline types for the I/Q phase/frequency estimator.
// ATAN[k] = round(atan(2^-k) / 2pi * 2^32); stages scale it down to the phase width.
package nco_iq_phase_est_pkg;

  localparam logic [31:0] ATAN [16] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
  };

  // Fields are sized for the widest supported configuration; stages use the low bits.
  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic [31:0]        z;
    logic               valid;
    logic               zero;
  } cordic_stage_t;

endpackage

// File: rtl/nco_cordic_vec_stage.sv
// One registered CORDIC vectoring micro-rotation (stage index K), held while clken is low.
module nco_cordic_vec_stage
  import nco_iq_phase_est_pkg::*;
#(
  parameter int K   = 0,
  parameter int XW  = 16,
  parameter int APR = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clken,
  input  cordic_stage_t stage_i,
  output cordic_stage_t stage_o
);

  localparam logic [APR-1:0] ATAN_K = APR'(ATAN[K] >> (32 - APR));

  logic signed [XW-1:0] x_in, y_in, x_nxt, y_nxt;
  logic [APR-1:0]       z_in, z_nxt;
  logic                 unused_in;
  cordic_stage_t        stage_d, stage_q;

  assign x_in      = stage_i.x[XW-1:0];
  assign y_in      = stage_i.y[XW-1:0];
  assign z_in      = stage_i.z[APR-1:0];
  assign unused_in = ^{stage_i.x, stage_i.y, stage_i.z};

  // Rotate towards y = 0, accumulating the applied angle in z.
  always_comb begin
    if (!y_in[XW-1]) begin
      x_nxt = x_in + (y_in >>> K);
      y_nxt = y_in - (x_in >>> K);
      z_nxt = z_in + ATAN_K;
    end else begin
      x_nxt = x_in - (y_in >>> K);
      y_nxt = y_in + (x_in >>> K);
      z_nxt = z_in - ATAN_K;
    end
    stage_d   = stage_i;
    stage_d.x = 32'(x_nxt);
    stage_d.y = 32'(y_nxt);
    stage_d.z = 32'(z_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else if (clken) begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/nco_iq_phase_est.sv
// I/Q -> phase and per-sample phase increment: pre-rotation, CORDIC vectoring, differentiator.
// Define NCO_IQ_PHASE_EST_AVG_EN to average 2^avg_log2 increments per output strobe.
module nco_iq_phase_est
  import nco_iq_phase_est_pkg::*;
#(
  parameter int mpr      = 14,
  parameter int apr      = 32,
  parameter int iter     = 14,
  parameter int avg_log2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  in_valid,
  input  logic signed [mpr-1:0] i_in,
  input  logic signed [mpr-1:0] q_in,
  output logic [apr-1:0]        phase_o,
  output logic [apr-1:0]        phi_inc_o,
  output logic                  out_valid
);

  localparam int XW = mpr + 2;
  localparam logic [apr-1:0] HALF_TURN = {1'b1, {(apr-1){1'b0}}};

  if (iter < 1 || iter > 16 || apr < 2 || apr > 32 || mpr < 2 || mpr > 30 || avg_log2 < 1) begin : g_bad_params
    $error("nco_iq_phase_est: unsupported parameter set");
  end

  logic signed [XW-1:0] i_ext, q_ext;
  cordic_stage_t        pre_d, pre_q;
  cordic_stage_t        stg [iter+1];

  assign i_ext = XW'(i_in);
  assign q_ext = XW'(q_in);

  // Fold the left half-plane onto the right so the CORDIC only sees +/-90 degrees.
  always_comb begin
    pre_d       = '0;
    pre_d.valid = in_valid;
    pre_d.zero  = (i_in == '0) && (q_in == '0);
    if (i_in[mpr-1]) begin
      pre_d.x = 32'(-i_ext);
      pre_d.y = 32'(-q_ext);
      pre_d.z = 32'(HALF_TURN);
    end else begin
      pre_d.x = 32'(i_ext);
      pre_d.y = 32'(q_ext);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else if (clken) begin
      pre_q <= pre_d;
    end
  end

  assign stg[0] = pre_q;

  for (genvar gi = 0; gi < iter; gi++) begin : g_stage
    nco_cordic_vec_stage #(
      .K   (gi),
      .XW  (XW),
      .APR (apr)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .clken   (clken),
      .stage_i (stg[gi]),
      .stage_o (stg[gi+1])
    );
  end

  cordic_stage_t  fin;
  logic [apr-1:0] z_fin, delta;
  logic           unused_fin;
  logic [apr-1:0] phase_q, phase_d, inc_q, inc_d, prev_q, prev_d;
  logic           primed_q, primed_d, valid_q, valid_d;

  assign fin        = stg[iter];
  assign z_fin      = fin.z[apr-1:0];
  assign delta      = z_fin - prev_q;
  assign unused_fin = ^{fin.x, fin.y, fin.z};

`ifdef NCO_IQ_PHASE_EST_AVG_EN
  localparam int AW = apr + avg_log2;

  logic signed [AW-1:0]  acc_q, acc_d, acc_sum;
  logic [avg_log2-1:0]   cnt_q, cnt_d;
  logic [apr-1:0]        blk_phase, blk_inc;

  // Zero samples count as a zero increment; the priming sample contributes nothing.
  always_comb begin
    phase_d   = phase_q;
    inc_d     = inc_q;
    prev_d    = prev_q;
    primed_d  = primed_q;
    valid_d   = 1'b0;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    blk_phase = fin.zero ? '0 : z_fin;
    blk_inc   = fin.zero ? '0 : delta;
    acc_sum   = acc_q + AW'($signed(blk_inc));
    if (fin.valid) begin
      if (!fin.zero) begin
        prev_d   = z_fin;
        primed_d = 1'b1;
      end
      if (fin.zero || primed_q) begin
        if (&cnt_q) begin
          phase_d = blk_phase;
          inc_d   = apr'(acc_sum >>> avg_log2);
          acc_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b1;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_q + avg_log2'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clken) begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    phase_d  = phase_q;
    inc_d    = inc_q;
    prev_d   = prev_q;
    primed_d = primed_q;
    valid_d  = 1'b0;
    if (fin.valid) begin
      if (fin.zero) begin
        phase_d = '0;
        inc_d   = '0;
        valid_d = 1'b1;
      end else begin
        prev_d   = z_fin;
        primed_d = 1'b1;
        if (primed_q) begin
          phase_d = z_fin;
          inc_d   = delta;
          valid_d = 1'b1;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= '0;
      inc_q    <= '0;
      prev_q   <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (clken) begin
      phase_q  <= phase_d;
      inc_q    <= inc_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
    end
  end

  assign phase_o   = phase_q;
  assign phi_inc_o = inc_q;
  // A held strobe must not be seen again while the pipeline is frozen.
  assign out_valid = valid_q & clken;

endmodule

// File: tb/tb_nco_iq_phase_est.sv
// Directed bench for nco_iq_phase_est: ideal atan2 reference model plus per-cycle strobe checker.
module tb_nco_iq_phase_est;

  localparam int  LAT  = 16;
  localparam real PI2  = 6.283185307179586;
  localparam real FULL = 4294967296.0;
  localparam int  PH_TOL = 1 << 18;
`ifdef NCO_IQ_PHASE_EST_AVG_EN
  localparam int  INC_TOL = 1 << 14;
  localparam int  BLK     = 16;
`else
  localparam int  INC_TOL = 1 << 18;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               clken = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [13:0] i_in = '0;
  logic signed [13:0] q_in = '0;
  logic [31:0]        phase_o, phi_inc_o;
  logic               out_valid;

  nco_iq_phase_est #(.mpr(14), .apr(32), .iter(14), .avg_log2(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .in_valid  (in_valid),
    .i_in      (i_in),
    .q_in      (q_in),
    .phase_o   (phase_o),
    .phi_inc_o (phi_inc_o),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] ph;
    logic [31:0] inc;
    bit          exact;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] log_ph[$];
  logic [31:0] log_inc[$];
  int unsigned log_cyc[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned en_edges = 0;
  int unsigned abs_cyc = 0;
  real         m_prev = 0.0;
  bit          m_primed = 1'b0;
  real         m_acc = 0.0;
  int          m_cnt = 0;

  function automatic bit near(input logic [31:0] a, input logic [31:0] b, input int tol);
    int d;
    d = int'(a - b);
    if (d < 0) d = -d;
    return d <= tol;
  endfunction

  function automatic logic [31:0] r2w(input real r);
    longint t;
    t = longint'(r);
    return t[31:0];
  endfunction

  function automatic real wrap_s(input real d);
    if (d >= FULL / 2.0) return d - FULL;
    if (d < -FULL / 2.0) return d + FULL;
    return d;
  endfunction

  task automatic chk_near(input string nm, input logic [31:0] act, input logic [31:0] req, input int tol);
    tests++;
    if (!near(act, req, tol)) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h +/- %0d", nm, act, req, tol);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    m_primed = 1'b0;
    m_prev   = 0.0;
    m_acc    = 0.0;
    m_cnt    = 0;
  endtask

  // Ideal behaviour: phase = atan2(q,i) in turns * 2^32, increment = wrapped phase difference.
  task automatic model_accept(input int i, input int q);
    exp_t e;
    real  ph, d;
    bit   isz;
    isz = (i == 0) && (q == 0);
    ph  = 0.0;
    d   = 0.0;
    if (!isz) begin
      ph = $atan2(real'(q), real'(i)) / PI2 * FULL;
      if (ph < 0.0) ph = ph + FULL;
      if (!m_primed) begin
        m_primed = 1'b1;
        m_prev   = ph;
        return;
      end
      d      = wrap_s(ph - m_prev);
      m_prev = ph;
    end
    e.due = en_edges + LAT - 1;
`ifdef NCO_IQ_PHASE_EST_AVG_EN
    m_acc = m_acc + d;
    m_cnt++;
    if (m_cnt < BLK) return;
    e.ph    = r2w(ph);
    e.inc   = r2w(m_acc / real'(BLK));
    e.exact = 1'b0;
    m_acc   = 0.0;
    m_cnt   = 0;
`else
    e.ph    = r2w(ph);
    e.inc   = r2w(d);
    e.exact = isz;
`endif
    expq.push_back(e);
  endtask

  always @(posedge clk) begin
    abs_cyc++;
    if (reset_n && clken) begin
      en_edges++;
      if (in_valid) model_accept(int'(i_in), int'(q_in));
    end
  end

  bit   want;
  exp_t cur;
  always @(negedge clk) begin
    want = reset_n && clken && (expq.size() > 0) && (expq[0].due == en_edges);
    if (out_valid !== want) begin
      tests++;
      fails++;
      $display("FAIL strobe: out_valid=%b, required %b (cycle %0d)", out_valid, want, abs_cyc);
    end
    if (want) begin
      cur = expq.pop_front();
      if (out_valid === 1'b1) begin
        chk_near("phase", phase_o, cur.ph, cur.exact ? 0 : PH_TOL);
        chk_near("phi_inc", phi_inc_o, cur.inc, cur.exact ? 0 : INC_TOL);
      end
    end
    if (out_valid === 1'b1) begin
      log_ph.push_back(phase_o);
      log_inc.push_back(phi_inc_o);
      log_cyc.push_back(abs_cyc);
    end
  end

  task automatic drive(input int i, input int q, input bit v);
    @(posedge clk);
    #1;
    in_valid = v;
    i_in     = 14'(i);
    q_in     = 14'(q);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 1'b0);
  endtask

  task automatic send_phase(input logic [31:0] ph);
    real a;
    a = real'(ph) / FULL * PI2;
    drive(int'(8191.0 * $cos(a)), int'(8191.0 * $sin(a)), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  int          base;
  int          bad;
  int unsigned c0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_near("rst_phase", phase_o, 32'h0, 0);
    chk_near("rst_inc", phi_inc_o, 32'h0, 0);
    chk_int("rst_valid", int'(out_valid), 0);
    reset_n = 1'b1;

`ifndef NCO_IQ_PHASE_EST_AVG_EN
    // Axis samples: first primes, then +90 and +90 degree steps.
    base = log_ph.size();
    drive(8191, 0, 1'b1);
    drive(0, 8191, 1'b1);
    c0 = abs_cyc;
    drive(-8191, 0, 1'b1);
    idle(LAT + 4);
    chk_int("axis_count", log_ph.size() - base, 2);
    chk_near("axis_ph1", log_ph[base], 32'h4000_0000, PH_TOL);
    chk_near("axis_inc1", log_inc[base], 32'h4000_0000, PH_TOL);
    chk_near("axis_ph2", log_ph[base+1], 32'h8000_0000, PH_TOL);
    chk_near("axis_inc2", log_inc[base+1], 32'h4000_0000, PH_TOL);
    chk_int("axis_latency", int'(log_cyc[base] - c0), LAT);

    // Rotating phasor at 1/32 turn per sample.
    base = log_ph.size();
    for (int n = 0; n < 1000; n++) send_phase(32'(n) * 32'h0800_0000);
    idle(LAT + 4);
    chk_int("phasor_count", log_ph.size() - base, 1000);
    bad = 0;
    for (int n = base + 1; n < log_inc.size(); n++)
      if (!near(log_inc[n], 32'h0800_0000, PH_TOL)) bad++;
    chk_int("phasor_bad_incs", bad, 0);

    // Wrap-around in both directions.
    send_phase(32'hF000_0000);
    send_phase(32'h0800_0000);
    send_phase(32'hF000_0000);
    idle(LAT + 4);
    chk_near("wrap_up", log_inc[log_inc.size()-2], 32'h1800_0000, PH_TOL);
    chk_int("wrap_up_sign", int'(log_inc[log_inc.size()-2][31]), 0);
    chk_near("wrap_down", log_inc[log_inc.size()-1], 32'hE800_0000, PH_TOL);

    // Zero sample between two real samples.
    send_phase(32'h1000_0000);
    drive(0, 0, 1'b1);
    send_phase(32'h2000_0000);
    idle(LAT + 4);
    chk_near("zero_ph", log_ph[log_ph.size()-2], 32'h0, 0);
    chk_near("zero_inc", log_inc[log_inc.size()-2], 32'h0, 0);
    chk_near("after_zero_inc", log_inc[log_inc.size()-1], 32'h1000_0000, PH_TOL);

    // Five frozen cycles in flight; a sample offered while frozen must be ignored.
    send_phase(32'h3000_0000);
    c0 = abs_cyc;
    idle(3);
    @(posedge clk);
    #1;
    clken    = 1'b0;
    in_valid = 1'b1;
    i_in     = 14'sd100;
    q_in     = 14'sd100;
    repeat (5) @(posedge clk);
    #1;
    clken    = 1'b1;
    in_valid = 1'b0;
    idle(LAT + 4);
    chk_int("clken_shift", int'(log_cyc[log_cyc.size()-1] - c0), LAT + 5);
    chk_near("clken_inc", log_inc[log_inc.size()-1], 32'h1000_0000, PH_TOL);

    // Asynchronous reset with ten samples in flight.
    base = log_ph.size();
    for (int n = 0; n < 10; n++) send_phase(32'(n) * 32'h0400_0000);
    #2;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    chk_near("midrst_phase", phase_o, 32'h0, 0);
    chk_near("midrst_inc", phi_inc_o, 32'h0, 0);
    chk_int("midrst_valid", int'(out_valid), 0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    idle(LAT + 4);
    chk_int("midrst_discard", log_ph.size() - base, 0);
    send_phase(32'h1000_0000);
    send_phase(32'h1800_0000);
    idle(LAT + 4);
    chk_int("reprime_count", log_ph.size() - base, 1);
    chk_near("reprime_inc", log_inc[log_inc.size()-1], 32'h0800_0000, PH_TOL);
`else
    // Averaged phasor: one priming sample, then 20 blocks of 16 increments.
    base = log_ph.size();
    for (int n = 0; n <= 20 * BLK; n++) send_phase(32'(n) * 32'h0100_0000);
    idle(LAT + 4);
    chk_int("avg_count", log_ph.size() - base, 20);
    bad = 0;
    for (int n = base; n < log_inc.size(); n++)
      if (!near(log_inc[n], 32'h0100_0000, INC_TOL)) bad++;
    chk_int("avg_bad_incs", bad, 0);
`endif

    chk_int("drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
